// File: rtl/cq_pkg.sv
// Shared types and helpers for the circular-queue pointer controller.
package cq_pkg;

    typedef enum logic [0:0] {
        CQ_RUN   = 1'b0,
        CQ_FLUSH = 1'b1
    } cq_state_e;

    // Modulo-depth increment that works for non power-of-two depths.
    function automatic int unsigned cq_idx_inc(input int unsigned idx, input int unsigned depth);
        return (idx == depth - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cq_idx_counter.sv
// Modulo-DEPTH index counter with enable and synchronous clear (head/tail pointers).
module cq_idx_counter #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [IDX_W-1:0] idx_o
);
    import cq_pkg::*;

    logic [IDX_W-1:0] idx_d, idx_q;

    always_comb begin
        idx_d = idx_q;
        if (clr_i) begin
            idx_d = '0;
        end else if (en_i) begin
            idx_d = IDX_W'(cq_idx_inc(32'(idx_q), DEPTH));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx_o = idx_q;

endmodule

// File: rtl/cq_updn_cnt.sv
// Generic up/down counter with synchronous clear and load; clear beats load beats count.
module cq_updn_cnt #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] ld_val_i,
    input  logic             en_i,
    input  logic             dn_i,
    output logic [WIDTH-1:0] cnt_o
);
    logic [WIDTH-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (ld_i) begin
            cnt_d = ld_val_i;
        end else if (en_i) begin
            cnt_d = dn_i ? cnt_q - WIDTH'(1) : cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cq_ptr_ctl.sv
// Head/tail/occupancy controller for a circular queue with flush FSM.
// Optional registered almost_full_o output when LEN5_CQ_ALMOST_FULL_EN is defined.
module cq_ptr_ctl #(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned IDX_W        = $clog2(DEPTH),
    parameter int unsigned CNT_W        = $clog2(DEPTH + 1),
    parameter int unsigned FLUSH_CYCLES = 1
`ifdef LEN5_CQ_ALMOST_FULL_EN
    ,
    parameter int unsigned AF_THRESH    = DEPTH - 2
`endif
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
`ifdef LEN5_CQ_ALMOST_FULL_EN
    output logic             almost_full_o,
`endif
    input  logic             push_valid_i,
    output logic             push_ready_o,
    input  logic             pop_ready_i,
    output logic             pop_valid_o,
    output logic             wr_en_o,
    output logic             rd_en_o,
    output logic [IDX_W-1:0] tail_idx_o,
    output logic [IDX_W-1:0] head_idx_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);
    import cq_pkg::*;

    localparam int unsigned FC_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FC_W-1:0] FcLoad = FC_W'(FLUSH_CYCLES);

    cq_state_e       state_d, state_q;
    logic [FC_W-1:0] fc_d, fc_q;
    logic            flush_entry;
    logic            run;

    always_comb begin
        state_d     = state_q;
        fc_d        = fc_q;
        flush_entry = 1'b0;
        unique case (state_q)
            CQ_RUN: begin
                if (flush_i) begin
                    state_d     = CQ_FLUSH;
                    fc_d        = FcLoad;
                    flush_entry = 1'b1;
                end
            end
            CQ_FLUSH: begin
                // Any flush during the exit countdown restarts it.
                if (flush_i) begin
                    fc_d = FcLoad;
                end else if (fc_q <= FC_W'(1)) begin
                    state_d = CQ_RUN;
                    fc_d    = '0;
                end else begin
                    fc_d = fc_q - FC_W'(1);
                end
            end
            default: state_d = CQ_RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= CQ_RUN;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            fc_q    <= fc_d;
        end
    end

    assign run          = (state_q == CQ_RUN);
    assign empty_o      = (count_o == '0);
    assign full_o       = (count_o == CNT_W'(DEPTH));
    assign push_ready_o = run & ~full_o;
    assign pop_valid_o  = run & ~empty_o;
    // A flush request wins over any handshake in the same cycle.
    assign wr_en_o      = push_valid_i & push_ready_o & ~flush_i;
    assign rd_en_o      = pop_valid_o & pop_ready_i & ~flush_i;

    cq_idx_counter #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_tail (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (flush_entry),
        .en_i   (wr_en_o),
        .idx_o  (tail_idx_o)
    );

    cq_idx_counter #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_head (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (flush_entry),
        .en_i   (rd_en_o),
        .idx_o  (head_idx_o)
    );

    cq_updn_cnt #(
        .WIDTH (CNT_W)
    ) u_occ (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (flush_entry),
        .ld_i     (1'b0),
        .ld_val_i ('0),
        .en_i     (wr_en_o ^ rd_en_o),
        .dn_i     (rd_en_o & ~wr_en_o),
        .cnt_o    (count_o)
    );

`ifdef LEN5_CQ_ALMOST_FULL_EN
    logic [CNT_W-1:0] cnt_nxt;
    logic             af_d, af_q;

    always_comb begin
        cnt_nxt = count_o;
        if (flush_entry) begin
            cnt_nxt = '0;
        end else if (wr_en_o & ~rd_en_o) begin
            cnt_nxt = count_o + CNT_W'(1);
        end else if (rd_en_o & ~wr_en_o) begin
            cnt_nxt = count_o - CNT_W'(1);
        end
        af_d = (state_d == CQ_RUN) && (32'(cnt_nxt) >= AF_THRESH);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            af_q <= 1'b0;
        end else begin
            af_q <= af_d;
        end
    end

    assign almost_full_o = af_q;
`endif

    cnt_le_depth_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        32'(count_o) <= DEPTH);
    no_underflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(rd_en_o && !wr_en_o && empty_o));

endmodule

// File: tb/tb_cq_ptr_ctl.sv
// Scoreboard bench for cq_ptr_ctl: DEPTH=8 instance (a) and DEPTH=6 instance (b).
module tb_cq_ptr_ctl;

    logic clk;
    logic rst_n;

    logic       fl_a, pv_a, pr_a;
    logic       prdy_a, pval_a, wr_a, rd_a, empty_a, full_a;
    logic [2:0] tail_a, head_a;
    logic [3:0] cnt_a;

    logic       fl_b, pv_b, pr_b;
    logic       prdy_b, pval_b, wr_b, rd_b, empty_b, full_b;
    logic [2:0] tail_b, head_b;
    logic [2:0] cnt_b;

`ifdef LEN5_CQ_ALMOST_FULL_EN
    logic af_a, af_b;
`endif

    int n_vec = 0;
    int n_err = 0;
    int wq_a[$];
    int rq_a[$];
    int wq_b[$];
    int rq_b[$];

    cq_ptr_ctl #(.DEPTH(8)) u_dut_a (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .flush_i       (fl_a),
`ifdef LEN5_CQ_ALMOST_FULL_EN
        .almost_full_o (af_a),
`endif
        .push_valid_i  (pv_a),
        .push_ready_o  (prdy_a),
        .pop_ready_i   (pr_a),
        .pop_valid_o   (pval_a),
        .wr_en_o       (wr_a),
        .rd_en_o       (rd_a),
        .tail_idx_o    (tail_a),
        .head_idx_o    (head_a),
        .count_o       (cnt_a),
        .empty_o       (empty_a),
        .full_o        (full_a)
    );

    cq_ptr_ctl #(.DEPTH(6)) u_dut_b (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .flush_i       (fl_b),
`ifdef LEN5_CQ_ALMOST_FULL_EN
        .almost_full_o (af_b),
`endif
        .push_valid_i  (pv_b),
        .push_ready_o  (prdy_b),
        .pop_ready_i   (pr_b),
        .pop_valid_o   (pval_b),
        .wr_en_o       (wr_b),
        .rd_en_o       (rd_b),
        .tail_idx_o    (tail_b),
        .head_idx_o    (head_b),
        .count_o       (cnt_b),
        .empty_o       (empty_b),
        .full_o        (full_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every strobe pops the expected index issued by the stimulus.
    always @(negedge clk) begin
        if (wr_a) begin
            if (wq_a.size() == 0) chk("a_unexpected_wr", 1, 0);
            else chk("a_wr_tail", int'(tail_a), wq_a.pop_front());
        end
        if (rd_a) begin
            if (rq_a.size() == 0) chk("a_unexpected_rd", 1, 0);
            else chk("a_rd_head", int'(head_a), rq_a.pop_front());
        end
        if (wr_b) begin
            if (wq_b.size() == 0) chk("b_unexpected_wr", 1, 0);
            else chk("b_wr_tail", int'(tail_b), wq_b.pop_front());
        end
        if (rd_b) begin
            if (rq_b.size() == 0) chk("b_unexpected_rd", 1, 0);
            else chk("b_rd_head", int'(head_b), rq_b.pop_front());
        end
    end

    // Drive one cycle on instance a; ew/er >= 0 queue an expected strobe index.
    task automatic a_cyc(input logic pv, input logic pr, input logic fl, input int ew,
                         input int er);
        @(posedge clk);
        #1;
        pv_a = pv;
        pr_a = pr;
        fl_a = fl;
        if (ew >= 0) wq_a.push_back(ew);
        if (er >= 0) rq_a.push_back(er);
        @(negedge clk);
    endtask

    task automatic b_cyc(input logic pv, input logic pr, input int ew, input int er);
        @(posedge clk);
        #1;
        pv_b = pv;
        pr_b = pr;
        if (ew >= 0) wq_b.push_back(ew);
        if (er >= 0) rq_b.push_back(er);
        @(negedge clk);
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_count"}, int'(cnt_a), 0);
        chk({tag, "_empty"}, int'(empty_a), 1);
        chk({tag, "_full"}, int'(full_a), 0);
        chk({tag, "_push_ready"}, int'(prdy_a), 1);
        chk({tag, "_pop_valid"}, int'(pval_a), 0);
        chk({tag, "_wr_en"}, int'(wr_a), 0);
        chk({tag, "_rd_en"}, int'(rd_a), 0);
        chk({tag, "_head"}, int'(head_a), 0);
        chk({tag, "_tail"}, int'(tail_a), 0);
`ifdef LEN5_CQ_ALMOST_FULL_EN
        chk({tag, "_almost_full"}, int'(af_a), 0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        {fl_a, pv_a, pr_a} = '0;
        {fl_b, pv_b, pr_b} = '0;
        #2;
        chk_reset_a("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to full; tail 0..7 then wraps to 0.
        for (int i = 0; i < 8; i++) begin
            a_cyc(1'b1, 1'b0, 1'b0, i, -1);
            chk("fill_count", int'(cnt_a), i);
            chk("fill_push_ready", int'(prdy_a), 1);
        end
        a_cyc(1'b1, 1'b0, 1'b0, -1, -1);
        chk("full_count", int'(cnt_a), 8);
        chk("full_flag", int'(full_a), 1);
        chk("full_push_ready", int'(prdy_a), 0);
        chk("full_wr_en", int'(wr_a), 0);
        chk("full_tail_wrap", int'(tail_a), 0);

        // Full with push+pop request: only the pop fires.
        a_cyc(1'b1, 1'b1, 1'b0, -1, 0);
        chk("fullpop_rd_en", int'(rd_a), 1);
        chk("fullpop_wr_en", int'(wr_a), 0);
        a_cyc(1'b1, 1'b0, 1'b0, 0, -1);
        chk("afterpop_count", int'(cnt_a), 7);
        chk("afterpop_push_ready", int'(prdy_a), 1);
        a_cyc(1'b0, 1'b0, 1'b0, -1, -1);
        chk("refill_count", int'(cnt_a), 8);
        chk("refill_head", int'(head_a), 1);
        chk("refill_tail", int'(tail_a), 1);

        // Drain to 3, then 20 cycles of simultaneous push/pop across the wrap.
        for (int i = 1; i <= 5; i++) a_cyc(1'b0, 1'b1, 1'b0, -1, i);
        for (int k = 0; k < 20; k++) begin
            a_cyc(1'b1, 1'b1, 1'b0, (1 + k) % 8, (6 + k) % 8);
            chk("steady_count", int'(cnt_a), 3);
        end

        // Bring count to 5, then a one-cycle flush with push_valid held.
        a_cyc(1'b1, 1'b0, 1'b0, 5, -1);
        a_cyc(1'b1, 1'b0, 1'b0, 6, -1);
        a_cyc(1'b1, 1'b0, 1'b1, -1, -1);
        chk("flush_pre_count", int'(cnt_a), 5);
        chk("flush_wr_en", int'(wr_a), 0);
        a_cyc(1'b1, 1'b0, 1'b0, -1, -1);
        chk("flush_count", int'(cnt_a), 0);
        chk("flush_head", int'(head_a), 0);
        chk("flush_tail", int'(tail_a), 0);
        chk("flush_push_ready", int'(prdy_a), 0);
        chk("flush_pop_valid", int'(pval_a), 0);
        chk("flush_wr_en_hold", int'(wr_a), 0);
        a_cyc(1'b1, 1'b0, 1'b0, 0, -1);
        chk("postflush_push_ready", int'(prdy_a), 1);
        chk("postflush_wr_en", int'(wr_a), 1);

        // Push on up to 6 entries; almost_full tracks count >= 6.
        for (int i = 1; i <= 5; i++) begin
            a_cyc(1'b1, 1'b0, 1'b0, i, -1);
            chk("af_climb_count", int'(cnt_a), i);
`ifdef LEN5_CQ_ALMOST_FULL_EN
            chk("af_climb_low", int'(af_a), 0);
`endif
        end
        a_cyc(1'b0, 1'b1, 1'b0, -1, 0);
        chk("af_reach_count", int'(cnt_a), 6);
`ifdef LEN5_CQ_ALMOST_FULL_EN
        chk("af_reach_high", int'(af_a), 1);
`endif
        a_cyc(1'b0, 1'b1, 1'b0, -1, 1);
        chk("af_drop_count", int'(cnt_a), 5);
`ifdef LEN5_CQ_ALMOST_FULL_EN
        chk("af_drop_low", int'(af_a), 0);
`endif

        // Asynchronous reset mid-burst at count 4, checked before the next edge.
        @(posedge clk);
        #1;
        pv_a = 1'b1;
        pr_a = 1'b0;
        chk("burst_count", int'(cnt_a), 4);
        #2;
        rst_n = 1'b0;
        pv_a  = 1'b0;
        #1;
        chk_reset_a("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        a_cyc(1'b0, 1'b0, 1'b0, -1, -1);
        chk("post_rst_count", int'(cnt_a), 0);

        // DEPTH=6 instance: 13 push/pop pairs, indices wrap 5 -> 0.
        for (int i = 0; i < 13; i++) begin
            b_cyc(1'b1, 1'b0, i % 6, -1);
            b_cyc(1'b0, 1'b1, -1, i % 6);
            chk("b_count", int'(cnt_b), 1);
        end
        b_cyc(1'b0, 1'b0, -1, -1);
        chk("b_final_head", int'(head_b), 1);
        chk("b_final_tail", int'(tail_b), 1);
        chk("b_final_empty", int'(empty_b), 1);

        chk("a_wr_left", wq_a.size(), 0);
        chk("a_rd_left", rq_a.size(), 0);
        chk("b_wr_left", wq_b.size(), 0);
        chk("b_rd_left", rq_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
